// File: rtl/dm_responder.sv
// dm_responder: multi-cycle target for the MEM-stage load/store request port.
// Accepts one word-wide request at a time and holds it for LATENCY cycles.
// It then returns a single-cycle rvalid carrying the read data, or a write
// acknowledge (rdata = 0).
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous reset, active-low
//   req    request valid from the MEM stage
//   we     1 = write, 0 = read (sampled with req)
//   addr   word address
//   wdata  store data
//   be     byte enables for writes (be[i] -> wdata[8i+7:8i])
//   ready  responder is idle and accepts req this cycle
//   rvalid one-cycle response strobe
//   rdata  read data, zero unless rvalid on an in-range read
//   err    address out of range, meaningful only with rvalid
//   busy   a request is in flight
module dm_responder #(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Counter reload: the access happens on the edge where the counter is
  // already 0, so LATENCY-1 gives LATENCY edges from accept to RESP.
  localparam logic [3:0] RELOAD = 4'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [3:0]        count_reg, count_next;
  logic              capture;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        be_reg;
  logic              in_range;
  logic              access;
  logic [31:0]       rd_word;

  // Compare in 32 bits so DEPTH == 2**ADDR_W is handled without overflow.
  assign in_range = ({{(32-ADDR_W){1'b0}}, addr_reg} < 32'(DEPTH));
  // During reset the state is forced to IDLE, so no access can fire.
  assign access   = (state_reg == WAIT) && (count_reg == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      be_reg    <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (capture) begin
        we_reg    <= we;
        addr_reg  <= addr;
        wdata_reg <= wdata;
        be_reg    <= be;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          capture    = 1'b1;
          count_next = RELOAD;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (count_reg != 4'd0) begin
          count_next = count_reg - 4'd1;
        end else begin
          state_next = RESP;
        end
      end
      RESP: begin
        // No back-pressure on the response.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One byte-wide RAM per lane so each lane writes independently under be.
  // Storage is not reset; the read register holds its value and is masked
  // on the output outside the response cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] rd_reg;

      always_ff @(posedge clk) begin
        if (access && in_range) begin
          if (we_reg) begin
            if (be_reg[gi]) begin
              mem[addr_reg] <= wdata_reg[8*gi +: 8];
            end
          end else begin
            rd_reg <= mem[addr_reg];
          end
        end
      end

      assign rd_word[8*gi +: 8] = rd_reg;
    end
  endgenerate

  assign ready  = (state_reg == IDLE);
  assign busy   = (state_reg != IDLE);
  assign rvalid = (state_reg == RESP);
  assign err    = (state_reg == RESP) && !in_range;
  assign rdata  = ((state_reg == RESP) && !we_reg && in_range) ? rd_word : 32'd0;

endmodule
